// File: rtl/factorial_cu.sv
// Control unit for the factorial datapath: go/done handshake, datapath
// controls, MULT-iteration watchdog and status/debug outputs.
module factorial_cu #(
  parameter int unsigned MAX_ITER = 12,
  parameter int unsigned STATE_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               a_gt_b,
  input  logic               err,
  output logic               prod_mux_sel,
  output logic               prod_reg_ld,
  output logic               cnt_ld,
  output logic               cnt_en,
  output logic               out_mux_sel,
  output logic               done,
  output logic               error,
  output logic               busy,
  output logic [3:0]         iter_cnt,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned ITER_W = 4;
  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);
  localparam logic [ITER_W-1:0] ITER_SAT   = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_MULT  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ITER_W-1:0] r_iter;

  logic w_prod_mux_sel, w_prod_reg_ld, w_cnt_ld, w_cnt_en;
  logic w_out_mux_sel, w_done, w_error, w_busy;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (go) w_state_nxt = err ? S_ERROR : S_LOAD;
      end
      S_LOAD:  w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (!a_gt_b)                 w_state_nxt = S_DONE;
        else if (r_iter == ITER_LIMIT) w_state_nxt = S_ERROR;
        else                         w_state_nxt = S_MULT;
      end
      S_MULT:  w_state_nxt = S_CHECK;
      S_DONE:  if (!go) w_state_nxt = S_IDLE;
      S_ERROR: if (!go) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Moore decode of the upcoming state, registered so outputs track r_state
  always_comb begin
    w_prod_mux_sel = 1'b0;
    w_prod_reg_ld  = 1'b0;
    w_cnt_ld       = 1'b0;
    w_cnt_en       = 1'b0;
    w_out_mux_sel  = 1'b0;
    w_done         = 1'b0;
    w_error        = 1'b0;
    w_busy         = 1'b0;
    case (w_state_nxt)
      S_LOAD: begin
        w_cnt_ld      = 1'b1;
        w_prod_reg_ld = 1'b1;
        w_busy        = 1'b1;
      end
      S_CHECK: w_busy = 1'b1;
      S_MULT: begin
        w_prod_mux_sel = 1'b1;
        w_prod_reg_ld  = 1'b1;
        w_cnt_en       = 1'b1;
        w_busy         = 1'b1;
      end
      S_DONE: begin
        w_out_mux_sel = 1'b1;
        w_done        = 1'b1;
      end
      S_ERROR: w_error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_mux_sel <= 1'b0;
      prod_reg_ld  <= 1'b0;
      cnt_ld       <= 1'b0;
      cnt_en       <= 1'b0;
      out_mux_sel  <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      prod_mux_sel <= w_prod_mux_sel;
      prod_reg_ld  <= w_prod_reg_ld;
      cnt_ld       <= w_cnt_ld;
      cnt_en       <= w_cnt_en;
      out_mux_sel  <= w_out_mux_sel;
      done         <= w_done;
      error        <= w_error;
      busy         <= w_busy;
    end
  end

  // Iteration counter: cleared on the LOAD edge, saturating count of MULT cycles
  always_ff @(posedge clk) begin
    if (rst)                                      r_iter <= '0;
    else if (r_state == S_LOAD)                   r_iter <= '0;
    else if (r_state == S_MULT && r_iter != ITER_SAT) r_iter <= r_iter + ITER_W'(1);
  end

  assign iter_cnt = r_iter;
  assign state    = STATE_W'(r_state);

endmodule

// File: tb/tb_factorial_cu.sv
// Bench for factorial_cu: behavioural datapath plus a reference model of
// latency, iteration count and factorial value; a second instance tests the watchdog.
module tb_factorial_cu;

  logic clk = 1'b0;
  logic rst, go, go2;
  logic [3:0] n;

  logic prod_mux_sel, prod_reg_ld, cnt_ld, cnt_en, out_mux_sel;
  logic done, error, busy;
  logic [3:0] iter_cnt;
  logic [2:0] state;
  logic a_gt_b, err;

  logic prod_mux_sel2, prod_reg_ld2, cnt_ld2, cnt_en2, out_mux_sel2;
  logic done2, error2, busy2;
  logic [3:0] iter_cnt2;
  logic [2:0] state2;

  logic [3:0]  dp_cnt;
  logic [31:0] dp_prod;
  logic [31:0] fact_out;

  int n_assert = 0;
  int n_fail   = 0;
  int prev_state2;

  always #5 clk = ~clk;

  factorial_cu #(.MAX_ITER(12), .STATE_W(3)) dut (
    .clk(clk), .rst(rst), .go(go), .a_gt_b(a_gt_b), .err(err),
    .prod_mux_sel(prod_mux_sel), .prod_reg_ld(prod_reg_ld), .cnt_ld(cnt_ld),
    .cnt_en(cnt_en), .out_mux_sel(out_mux_sel), .done(done), .error(error),
    .busy(busy), .iter_cnt(iter_cnt), .state(state)
  );

  // Watchdog instance: a_gt_b stuck high, err never set
  factorial_cu #(.MAX_ITER(3), .STATE_W(3)) dut_wd (
    .clk(clk), .rst(rst), .go(go2), .a_gt_b(1'b1), .err(1'b0),
    .prod_mux_sel(prod_mux_sel2), .prod_reg_ld(prod_reg_ld2), .cnt_ld(cnt_ld2),
    .cnt_en(cnt_en2), .out_mux_sel(out_mux_sel2), .done(done2), .error(error2),
    .busy(busy2), .iter_cnt(iter_cnt2), .state(state2)
  );

  // Behavioural datapath: down-counter and product register
  always @(posedge clk) begin
    if (cnt_ld)      dp_cnt <= n;
    else if (cnt_en) dp_cnt <= dp_cnt - 4'd1;
    if (prod_reg_ld) dp_prod <= prod_mux_sel ? dp_prod * 32'(dp_cnt) : 32'd1;
  end

  assign a_gt_b   = (dp_cnt > 4'd1);
  assign err      = (n > 4'd12);
  assign fact_out = out_mux_sel ? dp_prod : 32'd0;

  function automatic int ref_fact(input int v);
    int r = 1;
    for (int i = 2; i <= v; i++) r *= i;
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock, then per-cycle invariants on both instances
  task automatic tick();
    prev_state2 = int'(state2);
    @(posedge clk);
    #1;
    chk("ld_en_excl", longint'(cnt_ld & cnt_en), 0);
    chk("prod_ld_state", longint'(prod_reg_ld && !(state == 3'd1 || state == 3'd3)), 0);
    chk("status_onehot0", longint'($countones({busy, done, error}) <= 1), 1);
    chk("wd_ld_en_excl", longint'(cnt_ld2 & cnt_en2), 0);
    chk("wd_status_onehot0", longint'($countones({busy2, done2, error2}) <= 1), 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, longint'(state), 0);
    chk({tag, "_iter"}, longint'(iter_cnt), 0);
    chk({tag, "_outs"}, longint'({prod_mux_sel, prod_reg_ld, cnt_ld, cnt_en,
                                  out_mux_sel, done, error, busy}), 0);
  endtask

  // Full run of n: per-cycle state sequence, latency, result, hold, release
  task automatic run_n(input int nv, input int hold);
    int lat, k;
    lat = 2 * (max1(nv) - 1) + 3;
    n  = 4'(nv);
    go = 1'b1;
    k  = 0;
    do begin
      tick();
      k++;
      if (k < lat) begin
        if (k == 1)          chk("seq_load", longint'(state), 1);
        else if (k % 2 == 0) chk("seq_check", longint'(state), 2);
        else                 chk("seq_mult", longint'(state), 3);
      end
    end while (!done && k < lat + 20);
    chk("latency", k, lat);
    chk("done_state", longint'(state), 4);
    chk("iter_final", longint'(iter_cnt), max1(nv) - 1);
    chk("fact_out", longint'(fact_out), ref_fact(nv));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_done", longint'(done), 1);
    end
    go = 1'b0;
    tick();
    chk("release_idle", longint'(state), 0);
    chk("release_out", longint'(fact_out), 0);
  endtask

  initial begin
    int k;
    rst = 1'b1; go = 1'b0; go2 = 1'b0; n = 4'd0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("idle");

    run_n(5, 5);
    run_n(0, 0);
    run_n(1, 1);
    run_n(12, 0);

    // err in IDLE goes straight to ERROR
    n = 4'd13; go = 1'b1;
    tick();
    chk("err_state", longint'(state), 5);
    chk("err_flag", longint'(error), 1);
    chk("err_outmux", longint'(out_mux_sel), 0);
    chk("err_no_cnt_ld", longint'(cnt_ld), 0);
    tick();
    chk("err_hold", longint'(state), 5);
    go = 1'b0;
    tick();
    chk("err_release", longint'(state), 0);

    // Reset mid-MULT with go held
    n = 4'd8; go = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!(state == 3'd3 && iter_cnt >= 4'd2) && k < 40);
    chk("reach_mult", longint'(state), 3);
    rst = 1'b1;
    tick();
    check_all_zero("rst_mid1");
    tick();
    check_all_zero("rst_mid2");
    rst = 1'b0;
    tick();
    chk("post_rst_load", longint'(state), 1);
    k = 0;
    do begin tick(); k++; end while (!done && k < 40);
    chk("post_rst_done", longint'(done), 1);
    chk("post_rst_fact", longint'(fact_out), ref_fact(8));
    go = 1'b0;
    tick();

    // Random runs
    for (int r = 0; r < 20; r++) run_n(int'($urandom_range(12, 0)), int'($urandom_range(3, 0)));

    // Watchdog trip with MAX_ITER=3
    go2 = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!error2 && k < 40);
    chk("wd_state", longint'(state2), 5);
    chk("wd_from_check", longint'(prev_state2), 2);
    chk("wd_iter", longint'(iter_cnt2), 3);
    chk("wd_outmux", longint'(out_mux_sel2), 0);
    go2 = 1'b0;
    tick();
    chk("wd_release", longint'(state2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
